i2s_receiver: RTL and testbench

I2S master receiver for a MEMS microphone. Generates SCK and WS from the system clock, deserializes SD into signed PCM samples, and pushes each completed sample into the downstream sample FIFO through a single-cycle write strobe. If the FIFO reports full, the sample is dropped and a sticky overflow flag is raised. The block sits between the microphone pins and the sample FIFO's write port.

---
 rtl/i2s_pkg.sv | 24 ++
 rtl/i2s_clkgen.sv | 62 ++++++
 rtl/i2s_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_i2s_receiver.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared types and default parameters for the I2S microphone receiver.
//   i2s_channel_e    : slot identifier carried alongside each pushed sample
//   DEF_*            : default divider / slot / sample geometry
//   slot_enabled()   : whether a given slot produces FIFO pushes
// -----------------------------------------------------------------------------
package i2s_pkg;

    typedef enum logic [0:0] {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_channel_e;

    localparam int unsigned DEF_CLK_DIV      = 32'd4;
    localparam int unsigned DEF_SLOT_WIDTH   = 32'd32;
    localparam int unsigned DEF_SAMPLE_WIDTH = 32'd24;

    // Mono capture keeps the left slot only; stereo keeps both.
    function automatic logic slot_enabled(input logic slot, input logic stereo);
        return stereo | ~slot;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// -----------------------------------------------------------------------------
// i2s_clkgen
// Divides clk down to the I2S bit clock and flags the clk cycle whose closing
// edge makes SCK rise or fall.
//   clk, rst_n : system clock, synchronous active-low reset
//   enable     : run/stop; when low SCK and the divider are held at 0
//   sck        : registered bit clock (half-period = CLK_DIV clk cycles)
//   rise_stb   : high in the cycle whose closing edge drives SCK 0->1
//   fall_stb   : high in the cycle whose closing edge drives SCK 1->0
// -----------------------------------------------------------------------------
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 32'd1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'd1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             sck_r;
    logic             toggle_s;

    // Toggle request: last divider count while running.
    always_comb begin
        toggle_s = 1'b0;
        if (enable && (div_cnt_r == DIV_LAST)) begin
            toggle_s = 1'b1;
        end else begin
            toggle_s = 1'b0;
        end
    end

    // Divider counter and SCK register; idle parks both at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= 1'b0;
        end else if (!enable) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= 1'b0;
        end else if (toggle_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= ~sck_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
            sck_r     <= sck_r;
        end
    end

    assign sck      = sck_r;
    assign rise_stb = toggle_s & ~sck_r;
    assign fall_stb = toggle_s & sck_r;

endmodule

// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
// I2S master receiver for a MEMS microphone. Generates SCK/WS, deserializes SD
// MSB-first into SAMPLE_WIDTH-bit samples and pushes each completed sample to
// the sample FIFO with a one-cycle strobe. A push that meets a full FIFO is
// dropped and raises a sticky overflow flag.
//   clk, rst_n        : system clock, synchronous active-low reset
//   enable_i          : run/stop; stopping aborts the current frame
//   i2s_sck_o         : bit clock to the microphone
//   i2s_ws_o          : word select (0 = left, 1 = right)
//   i2s_sd_i          : serial data from the microphone
//   wr_en_o           : FIFO write strobe (one cycle)
//   write_data_o      : captured sample, held until the next push
//   channel_o         : slot of the pushed sample, valid with wr_en_o
//   full_i            : FIFO full
//   overflow_o        : sticky drop indicator
//   clear_overflow_i  : clears overflow_o (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned SLOT_WIDTH   = DEF_SLOT_WIDTH,
    parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int unsigned STEREO       = 32'd0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    output logic                    i2s_sck_o,
    output logic                    i2s_ws_o,
    input  logic                    i2s_sd_i,
    output logic                    wr_en_o,
    output logic [SAMPLE_WIDTH-1:0] write_data_o,
    output logic                    channel_o,
    input  logic                    full_i,
    output logic                    overflow_o,
    input  logic                    clear_overflow_i
);

    localparam int unsigned      FRAME_BITS = 32'd2 * SLOT_WIDTH;
    localparam int unsigned      BIT_W      = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 32'd1);
    localparam logic [BIT_W-1:0] SLOT_LEN   = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0] LSB_POS    = BIT_W'(SAMPLE_WIDTH);
    localparam logic             STEREO_EN  = (STEREO != 32'd0);

    logic                    sck_s;
    logic                    rise_stb_s;
    logic                    fall_stb_s;

    logic [BIT_W-1:0]        bit_cnt_r;
    logic [BIT_W-1:0]        bit_cnt_nxt_s;
    logic [BIT_W-1:0]        slot_bit_s;
    logic                    slot_s;
    logic                    ws_r;

    logic [SAMPLE_WIDTH-1:0] shift_r;
    logic                    shift_en_s;
    logic                    push_trig_s;

    logic                    push_pend_r;
    i2s_channel_e            push_ch_r;
    logic                    accept_s;
    logic                    drop_s;

    logic                    wr_en_r;
    logic [SAMPLE_WIDTH-1:0] write_data_r;
    i2s_channel_e            channel_r;
    logic                    overflow_r;

    i2s_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable_i),
        .sck      (sck_s),
        .rise_stb (rise_stb_s),
        .fall_stb (fall_stb_s)
    );

    // Frame position decode: next bit count, slot, bit within slot, and the
    // capture/push qualifiers for the upcoming rise event.
    always_comb begin
        bit_cnt_nxt_s = {BIT_W{1'b0}};
        slot_s        = 1'b0;
        slot_bit_s    = {BIT_W{1'b0}};
        shift_en_s    = 1'b0;
        push_trig_s   = 1'b0;

        if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_nxt_s = {BIT_W{1'b0}};
        end else begin
            bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1'b1);
        end

        if (bit_cnt_r >= SLOT_LEN) begin
            slot_s     = 1'b1;
            slot_bit_s = bit_cnt_r - SLOT_LEN;
        end else begin
            slot_s     = 1'b0;
            slot_bit_s = bit_cnt_r;
        end

        // Bit 0 of each slot is the I2S one-bit delay; bits past the LSB are
        // padding from the microphone and are not captured.
        if (rise_stb_s && (slot_bit_s != {BIT_W{1'b0}}) && (slot_bit_s <= LSB_POS)) begin
            shift_en_s = 1'b1;
        end else begin
            shift_en_s = 1'b0;
        end

        if (rise_stb_s && (slot_bit_s == LSB_POS) && slot_enabled(slot_s, STEREO_EN)) begin
            push_trig_s = 1'b1;
        end else begin
            push_trig_s = 1'b0;
        end
    end

    // Frame bit counter and WS; WS follows the slot of the new count so it
    // changes on the same edge as the SCK fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            ws_r      <= 1'b0;
        end else if (!enable_i) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            ws_r      <= 1'b0;
        end else if (fall_stb_s) begin
            bit_cnt_r <= bit_cnt_nxt_s;
            ws_r      <= (bit_cnt_nxt_s >= SLOT_LEN);
        end else begin
            bit_cnt_r <= bit_cnt_r;
            ws_r      <= ws_r;
        end
    end

    // MSB-first shift register; SD is taken on the edge where SCK rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r <= {SAMPLE_WIDTH{1'b0}};
        end else if (!enable_i) begin
            shift_r <= {SAMPLE_WIDTH{1'b0}};
        end else if (shift_en_s) begin
            shift_r <= {shift_r[SAMPLE_WIDTH-2:0], i2s_sd_i};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Push request: set by the LSB rise event of an enabled slot, consumed on
    // the following edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            push_pend_r <= 1'b0;
            push_ch_r   <= CH_LEFT;
        end else if (!enable_i) begin
            push_pend_r <= 1'b0;
            push_ch_r   <= CH_LEFT;
        end else begin
            push_pend_r <= push_trig_s;
            if (push_trig_s) begin
                push_ch_r <= slot_s ? CH_RIGHT : CH_LEFT;
            end else begin
                push_ch_r <= push_ch_r;
            end
        end
    end

    // A pending push either lands in the FIFO or is dropped on full; a stop
    // in the same cycle discards it.
    always_comb begin
        accept_s = 1'b0;
        drop_s   = 1'b0;
        if (push_pend_r && enable_i) begin
            accept_s = ~full_i;
            drop_s   = full_i;
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
    end

    // FIFO write port registers; data and channel only move on a real push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_r      <= 1'b0;
            write_data_r <= {SAMPLE_WIDTH{1'b0}};
            channel_r    <= CH_LEFT;
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                write_data_r <= shift_r;
                channel_r    <= push_ch_r;
            end else begin
                write_data_r <= write_data_r;
                channel_r    <= channel_r;
            end
        end
    end

    // Sticky overflow; a drop outranks a clear, and run/stop leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clear_overflow_i) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign i2s_sck_o    = sck_s;
    assign i2s_ws_o     = ws_r;
    assign wr_en_o      = wr_en_r;
    assign write_data_o = write_data_r;
    assign channel_o    = channel_r;
    assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_i2s_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_receiver
// Directed bench for i2s_receiver: a mono and a stereo instance share the
// clock, reset, enable and a behavioural I2S microphone that plays
// L = 0xA5C3F1 / R = 0x123456. CLK_DIV = 2, SLOT_WIDTH = 32, SAMPLE_WIDTH = 24.
// -----------------------------------------------------------------------------
module tb_i2s_receiver;

    localparam logic [23:0] L_WORD = 24'hA5C3F1;
    localparam logic [23:0] R_WORD = 24'h123456;

    typedef struct {
        int          cyc;
        logic [23:0] data;
        logic        ch;
        logic        after_lsb;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        sd = 1'b0;
    logic        full_m = 1'b0;
    logic        full_s = 1'b0;
    logic        clr = 1'b0;
    logic        pad = 1'b0;

    logic        m_sck, m_ws, m_wr, m_ch, m_ovf;
    logic [23:0] m_data;
    logic        s_sck, s_ws, s_wr, s_ch, s_ovf;
    logic [23:0] s_data;

    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;

    // microphone / monitor state
    int          pos = 0;
    logic        prev_sck = 1'b0;
    logic        prev_ws = 1'b0;
    logic        lsb_evt = 1'b0;
    logic        lsb_ch = 1'b0;
    int          lsb_cyc = -10;
    logic [23:0] word;
    pulse_t      mq[$];
    pulse_t      sq[$];
    int          en_cyc = 0;

    i2s_receiver #(.CLK_DIV(2), .SLOT_WIDTH(32), .SAMPLE_WIDTH(24), .STEREO(0)) u_mono (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .i2s_sck_o(m_sck), .i2s_ws_o(m_ws), .i2s_sd_i(sd),
        .wr_en_o(m_wr), .write_data_o(m_data), .channel_o(m_ch),
        .full_i(full_m), .overflow_o(m_ovf), .clear_overflow_i(clr)
    );

    i2s_receiver #(.CLK_DIV(2), .SLOT_WIDTH(32), .SAMPLE_WIDTH(24), .STEREO(1)) u_st (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .i2s_sck_o(s_sck), .i2s_ws_o(s_ws), .i2s_sd_i(sd),
        .wr_en_o(s_wr), .write_data_o(s_data), .channel_o(s_ch),
        .full_i(full_s), .overflow_o(s_ovf), .clear_overflow_i(clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse capture plus the microphone: follows SCK/WS of the mono instance,
    // restarts the bit position on each WS change, drives SD after SCK falls.
    always @(negedge clk) begin
        if (m_wr === 1'b1) mq.push_back('{cyc, m_data, m_ch, (lsb_cyc == cyc - 1)});
        if (s_wr === 1'b1) sq.push_back('{cyc, s_data, s_ch, (lsb_cyc == cyc - 1)});
        lsb_evt = 1'b0;
        if (!rst_n || !enable_i) begin
            pos = 0;
            prev_sck = 1'b0;
            prev_ws = 1'b0;
        end else begin
            if (prev_sck && !m_sck) begin
                if (m_ws != prev_ws) pos = 0;
                else pos = pos + 1;
            end
            if (!prev_sck && m_sck && pos == 24) begin
                lsb_evt = 1'b1;
                lsb_ch = m_ws;
                lsb_cyc = cyc;
            end
            prev_sck = m_sck;
            prev_ws = m_ws;
        end
        word = m_ws ? R_WORD : L_WORD;
        if (pos >= 1 && pos <= 24) sd = word[24 - pos];
        else sd = pad;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic restart();
        enable_i = 1'b0;
        step();
        step();
        mq.delete();
        sq.delete();
        en_cyc = cyc;
        enable_i = 1'b1;
    endtask

    task automatic test_reset();
        logic sck_seen;
        logic toggled;
        rst_n = 1'b0;
        enable_i = 1'b1;
        sck_seen = 1'b0;
        repeat (5) begin
            step();
            if (m_sck || s_sck) sck_seen = 1'b1;
        end
        checks++; if (m_sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", m_sck); else passes++;
        checks++; if (m_ws !== 1'b0) $display("FAIL reset_ws: got %b want 0", m_ws); else passes++;
        checks++; if (m_wr !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", m_wr); else passes++;
        checks++; if (m_data !== 24'h000000) $display("FAIL reset_data: got %h want 000000", m_data); else passes++;
        checks++; if (m_ovf !== 1'b0) $display("FAIL reset_overflow: got %b want 0", m_ovf); else passes++;
        checks++; if (s_data !== 24'h000000) $display("FAIL reset_data_st: got %h want 000000", s_data); else passes++;
        checks++; if (sck_seen !== 1'b0) $display("FAIL reset_sck_quiet: got %b want 0", sck_seen); else passes++;
        rst_n = 1'b1;
        toggled = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (m_sck) toggled = 1'b1;
        end
        checks++; if (toggled !== 1'b1) $display("FAIL reset_release_sck: got %b want 1", toggled); else passes++;
    endtask

    task automatic test_left_only();
        int   ws_hi;
        int   rise0;
        int   rise1;
        logic p;
        ws_hi = 0;
        rise0 = -1;
        rise1 = -1;
        p = 1'b0;
        restart();
        for (int i = 0; i < 768; i++) begin
            step();
            if (m_ws) ws_hi++;
            if (!p && m_sck) begin
                if (rise0 < 0) rise0 = cyc;
                else if (rise1 < 0) rise1 = cyc;
            end
            p = m_sck;
        end
        checks++; if (mq.size() != 3) $display("FAIL mono_count: got %0d want 3", mq.size()); else passes++;
        checks++; if (rise1 - rise0 != 4) $display("FAIL mono_sck_period: got %0d want 4", rise1 - rise0); else passes++;
        checks++; if (ws_hi != 384) $display("FAIL mono_ws_high: got %0d want 384", ws_hi); else passes++;
        if (mq.size() >= 3) begin
            checks++; if (mq[0].cyc != en_cyc + 99) $display("FAIL mono_first_latency: got %0d want %0d", mq[0].cyc, en_cyc + 99); else passes++;
            for (int i = 0; i < 3; i++) begin
                checks++; if (mq[i].data !== L_WORD) $display("FAIL mono_data%0d: got %h want %h", i, mq[i].data, L_WORD); else passes++;
                checks++; if (mq[i].ch !== 1'b0) $display("FAIL mono_ch%0d: got %b want 0", i, mq[i].ch); else passes++;
            end
            checks++; if (mq[1].cyc - mq[0].cyc != 256) $display("FAIL mono_spacing1: got %0d want 256", mq[1].cyc - mq[0].cyc); else passes++;
            checks++; if (mq[2].cyc - mq[1].cyc != 256) $display("FAIL mono_spacing2: got %0d want 256", mq[2].cyc - mq[1].cyc); else passes++;
        end
    endtask

    task automatic test_stereo();
        restart();
        repeat (600) step();
        checks++; if (sq.size() != 4) $display("FAIL st_count: got %0d want 4", sq.size()); else passes++;
        checks++; if (mq.size() != 2) $display("FAIL st_mono_count: got %0d want 2", mq.size()); else passes++;
        if (sq.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (sq[i].data !== ((i % 2 == 0) ? L_WORD : R_WORD))
                    $display("FAIL st_data%0d: got %h want %h", i, sq[i].data, (i % 2 == 0) ? L_WORD : R_WORD);
                else passes++;
                checks++; if (sq[i].ch !== 1'(i % 2)) $display("FAIL st_ch%0d: got %b want %0d", i, sq[i].ch, i % 2); else passes++;
                checks++; if (sq[i].after_lsb !== 1'b1) $display("FAIL st_lsb_latency%0d: got %b want 1", i, sq[i].after_lsb); else passes++;
                if (i > 0) begin
                    checks++; if (sq[i].cyc - sq[i-1].cyc != 128) $display("FAIL st_spacing%0d: got %0d want 128", i, sq[i].cyc - sq[i-1].cyc); else passes++;
                end
            end
        end
    endtask

    task automatic wait_left_lsb(output logic found);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (lsb_evt && lsb_ch == 1'b0) found = 1'b1;
        end
    endtask

    task automatic test_overflow();
        logic found;
        logic got;
        restart();
        wait_left_lsb(found);
        checks++; if (found !== 1'b1) $display("FAIL ovf_wait1: got %b want 1", found); else passes++;
        full_m = 1'b1;
        step();
        checks++; if (m_wr !== 1'b0) $display("FAIL ovf_drop_wr_en: got %b want 0", m_wr); else passes++;
        checks++; if (m_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", m_ovf); else passes++;
        checks++; if (mq.size() != 0) $display("FAIL ovf_no_push: got %0d want 0", mq.size()); else passes++;
        full_m = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            if (mq.size() > 0) got = 1'b1;
        end
        checks++; if (got !== 1'b1) $display("FAIL ovf_next_push: got %b want 1", got); else passes++;
        if (got) begin
            checks++; if (mq[0].data !== L_WORD) $display("FAIL ovf_next_data: got %h want %h", mq[0].data, L_WORD); else passes++;
        end
        checks++; if (m_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", m_ovf); else passes++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (m_ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", m_ovf); else passes++;
        wait_left_lsb(found);
        checks++; if (found !== 1'b1) $display("FAIL ovf_wait2: got %b want 1", found); else passes++;
        full_m = 1'b1;
        clr = 1'b1;
        step();
        checks++; if (m_ovf !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", m_ovf); else passes++;
        full_m = 1'b0;
        clr = 1'b0;
        step();
        checks++; if (m_ovf !== 1'b1) $display("FAIL ovf_hold: got %b want 1", m_ovf); else passes++;
        enable_i = 1'b0;
        step();
        checks++; if (m_ovf !== 1'b1) $display("FAIL ovf_enable_keep: got %b want 1", m_ovf); else passes++;
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic found;
        logic sck_idle_hi;
        logic got;
        restart();
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (pos == 10 && !m_ws && m_sck) found = 1'b1;
        end
        checks++; if (found !== 1'b1) $display("FAIL drop_wait: got %b want 1", found); else passes++;
        enable_i = 1'b0;
        step();
        checks++; if (m_sck !== 1'b0) $display("FAIL drop_sck: got %b want 0", m_sck); else passes++;
        checks++; if (m_ws !== 1'b0) $display("FAIL drop_ws: got %b want 0", m_ws); else passes++;
        sck_idle_hi = 1'b0;
        repeat (300) begin
            step();
            if (m_sck || m_ws || s_sck) sck_idle_hi = 1'b1;
        end
        checks++; if (sck_idle_hi !== 1'b0) $display("FAIL drop_idle_quiet: got %b want 0", sck_idle_hi); else passes++;
        checks++; if (mq.size() + sq.size() != 0) $display("FAIL drop_no_push: got %0d want 0", mq.size() + sq.size()); else passes++;
        restart();
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            step();
            if (mq.size() > 0) got = 1'b1;
        end
        checks++; if (got !== 1'b1) $display("FAIL drop_reenable_push: got %b want 1", got); else passes++;
        if (got) begin
            checks++; if (mq[0].data !== L_WORD) $display("FAIL drop_reenable_data: got %h want %h", mq[0].data, L_WORD); else passes++;
            checks++; if (mq[0].ch !== 1'b0) $display("FAIL drop_reenable_ch: got %b want 0", mq[0].ch); else passes++;
            checks++; if (mq[0].cyc != en_cyc + 99) $display("FAIL drop_reenable_latency: got %0d want %0d", mq[0].cyc, en_cyc + 99); else passes++;
        end
    endtask

    task automatic test_padding();
        pad = 1'b1;
        restart();
        repeat (300) step();
        checks++; if (mq.size() != 1) $display("FAIL pad_count: got %0d want 1", mq.size()); else passes++;
        checks++; if (sq.size() != 2) $display("FAIL pad_st_count: got %0d want 2", sq.size()); else passes++;
        if (mq.size() >= 1) begin
            checks++; if (mq[0].data !== L_WORD) $display("FAIL pad_left: got %h want %h", mq[0].data, L_WORD); else passes++;
        end
        if (sq.size() >= 2) begin
            checks++; if (sq[0].data !== L_WORD) $display("FAIL pad_st_left: got %h want %h", sq[0].data, L_WORD); else passes++;
            checks++; if (sq[1].data !== R_WORD) $display("FAIL pad_st_right: got %h want %h", sq[1].data, R_WORD); else passes++;
        end
        pad = 1'b0;
    endtask

    initial begin
        test_reset();
        test_left_only();
        test_stereo();
        test_overflow();
        test_enable_drop();
        test_padding();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
